// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, synchronous imem reads, and a small credit-checked
// FIFO presenting fetched words to the decoder; redirects flush all stale fetches.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PC_INIT = {RESET_PC[ADDR_W-1:2], 2'b00};

    typedef struct packed {
        logic [31:0]       word;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q;
    logic [CNT_W-1:0]  count_q, count_d;
    entry_t            fifo_q [DEPTH];
    entry_t            fifo_d [DEPTH];
    logic              pop;
    logic              push;
    logic [SUM_W-1:0]  credit_used;
    logic [IDX_W-1:0]  tail_idx;
    logic              unused_redirect_bits;

    // Redirect hides the head so nothing is consumed in the flush cycle.
    assign instr_valid = (count_q != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight_q && !redirect_valid;

    // Credit covers buffered words plus the read still in flight.
    assign credit_used = SUM_W'(count_q) + SUM_W'(inflight_q) - SUM_W'(pop);
    assign imem_req    = rst_n && !redirect_valid && (credit_used < SUM_W'(DEPTH));
    assign imem_addr   = pc_q;

    assign instruction = fifo_q[0].word;
    assign instr_pc    = fifo_q[0].pc;
    assign tail_idx    = IDX_W'(count_q - CNT_W'(pop));

    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Next-state for PC, count and the shift-register FIFO (entry 0 is the head).
    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        fifo_d        = fifo_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_d = '0;
        end else begin
            if (imem_req) begin
                pc_d          = pc_q + ADDR_W'(4);
                inflight_pc_d = pc_q;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    fifo_d[i] = fifo_q[i+1];
                end
            end
            if (push) begin
                fifo_d[tail_idx] = {imem_rdata, inflight_pc_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= PC_INIT;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= imem_req;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            fifo_q        <= fifo_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle table plus reset and randomized redirect/backpressure sequences
// for instr_fetch_unit, with a behavioural instruction memory.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    int n_vec = 0;
    int n_bad = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'h0) return 32'h2135_0001;
        if (a == 32'h4) return 32'h4741_0001;
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Synchronous memory: data valid the cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memw(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] ins;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] ipc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc;
        v.ins = memw(ipc);
        return v;
    endfunction

    initial begin
        logic [31:0] exp_pc;
        logic        prev_stall;
        logic [31:0] prev_pc;
        int          accepts;

        // Cycle 0 is the first cycle after rst_n release.
        tbl[0]  = mk(1, 0, 0,            1, 32'h0,        0, 0);
        tbl[1]  = mk(1, 0, 0,            1, 32'h4,        0, 0);
        tbl[2]  = mk(1, 0, 0,            1, 32'h8,        1, 32'h0);
        tbl[3]  = mk(1, 0, 0,            1, 32'hC,        1, 32'h4);
        for (int i = 4; i < 10; i++)
            tbl[i] = mk(0, 0, 0,         0, 32'h10,       1, 32'h8);
        tbl[10] = mk(1, 0, 0,            1, 32'h10,       1, 32'h8);
        tbl[11] = mk(1, 0, 0,            1, 32'h14,       1, 32'hC);
        tbl[12] = mk(1, 0, 0,            1, 32'h18,       1, 32'h10);
        tbl[13] = mk(1, 1, 32'h100,      0, 32'h1C,       0, 0);
        tbl[14] = mk(1, 0, 0,            1, 32'h100,      0, 0);
        tbl[15] = mk(1, 0, 0,            1, 32'h104,      0, 0);
        tbl[16] = mk(1, 0, 0,            1, 32'h108,      1, 32'h100);
        tbl[17] = mk(1, 1, 32'h103,      0, 32'h10C,      0, 0);
        tbl[18] = mk(1, 0, 0,            1, 32'h100,      0, 0);
        tbl[19] = mk(1, 1, 32'h40,       0, 32'h104,      0, 0);
        tbl[20] = mk(1, 1, 32'hFFFF_FFFF, 0, 32'h40,      0, 0);
        tbl[21] = mk(1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0);
        tbl[22] = mk(1, 0, 0,            1, 32'h0,        0, 0);
        tbl[23] = mk(1, 0, 0,            1, 32'h4,        1, 32'hFFFF_FFFC);
        tbl[24] = mk(1, 0, 0,            1, 32'h8,        1, 32'h0);
        tbl[25] = mk(0, 0, 0,            0, 32'hC,        1, 32'h4);

        #1 rst_n = 1'b0;
        #7;
        check("reset imem_req", 32'(imem_req), 32'h0);
        check("reset instr_valid", 32'(instr_valid), 32'h0);
        check("reset instruction", instruction, 32'h0);
        check("reset instr_pc", instr_pc, 32'h0);
        check("reset imem_addr", imem_addr, 32'h0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            instr_ready    = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            if (i == 0) rst_n = 1'b1;
            #1;
            check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            check($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].addr);
            check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                check($sformatf("v%0d instr_pc", i), instr_pc, tbl[i].ipc);
                check($sformatf("v%0d instruction", i), instruction, tbl[i].ins);
            end
        end

        // Mid-stream reset with two words buffered.
        @(negedge clk);
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst instr_valid", 32'(instr_valid), 32'h0);
        check("midrst imem_req", 32'(imem_req), 32'h0);
        check("midrst instruction", instruction, 32'h0);
        check("midrst instr_pc", instr_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel0 imem_req", 32'(imem_req), 32'h1);
        check("rel0 imem_addr", imem_addr, 32'h0);
        check("rel0 instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk); #1;
        check("rel1 imem_addr", imem_addr, 32'h4);
        check("rel1 instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk); #1;
        check("rel2 instr_valid", 32'(instr_valid), 32'h1);
        check("rel2 instr_pc", instr_pc, 32'h0);
        check("rel2 instruction", instruction, 32'h2135_0001);
        @(negedge clk); #1;
        check("rel3 instr_pc", instr_pc, 32'h4);
        check("rel3 instruction", instruction, 32'h4741_0001);

        // Random backpressure and redirects against a sequential-order scoreboard.
        exp_pc = 32'h8;
        prev_stall = 1'b0;
        prev_pc = '0;
        accepts = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            instr_ready    = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            #1;
            if (imem_req && imem_addr[1:0] != 2'b00)
                check("rnd addr align", imem_addr, {imem_addr[31:2], 2'b00});
            if (redirect_valid) begin
                check("rnd redirect valid", 32'(instr_valid), 32'h0);
                check("rnd redirect req", 32'(imem_req), 32'h0);
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (prev_stall) begin
                    check("rnd stall valid", 32'(instr_valid), 32'h1);
                    check("rnd stall pc", instr_pc, prev_pc);
                end
                if (instr_valid && instr_ready) begin
                    check("rnd accept pc", instr_pc, exp_pc);
                    check("rnd accept word", instruction, memw(exp_pc));
                    exp_pc = exp_pc + 32'h4;
                    accepts++;
                end
            end
            prev_stall = instr_valid && !instr_ready && !redirect_valid;
            prev_pc    = instr_pc;
        end
        check("rnd progress", 32'(accepts > 1000), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
